// File: rtl/adc_sample_averager.sv
// Boxcar averager for the AD4008 sample stream: sums 2**LOG2_AVG samples, emits a
// round-half-up mean into a first-word-fall-through result FIFO with drop accounting.
`timescale 1ns/1ps

module adc_sample_averager #(
    parameter int ADC_WIDTH  = 16,
    parameter int LOG2_AVG   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic                          new_data_flag,
    input  logic [ADC_WIDTH-1:0]          amplified_data,
    output logic                          avg_valid,
    output logic [ADC_WIDTH-1:0]          avg_data,
    input  logic                          avg_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    input  logic                          clear_status
);

    localparam int N       = 1 << LOG2_AVG;
    localparam int SUM_W   = ADC_WIDTH + LOG2_AVG + 1;
    localparam int CNT_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam logic [SUM_W-1:0] ROUND_C = SUM_W'(N / 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SUM_W-1:0]       acc_r;
    logic [CNT_W-1:0]       sample_cnt_r;
    logic                   take_s;
    logic                   window_done_s;
    logic [SUM_W-1:0]       sum_s;
    logic [ADC_WIDTH-1:0]   result_s;

    logic                   res_valid_r;
    logic [ADC_WIDTH-1:0]   res_data_r;

    logic [ADC_WIDTH-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW-1:0]          rd_ptr_nxt_s;
    logic [LW-1:0]          count_r;
    logic [LW-1:0]          count_nxt_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   drop_s;
    logic [ADC_WIDTH-1:0]   head_nxt_s;
    logic                   avg_valid_r;
    logic [ADC_WIDTH-1:0]   avg_data_r;
    logic                   overflow_r;
    logic [15:0]            drop_cnt_r;

    // FSM state register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and window datapath decode
    always_comb begin
        state_nxt_s   = state_r;
        take_s        = 1'b0;
        window_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                    take_s      = new_data_flag;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (take_s && (sample_cnt_r == CNT_W'(N - 1))) begin
            window_done_s = 1'b1;
        end else begin
            window_done_s = 1'b0;
        end
        sum_s    = acc_r + SUM_W'(amplified_data);
        // Full-window sum plus half an LSB, so the mean rounds half-up.
        result_s = ADC_WIDTH'((sum_s + ROUND_C) >> LOG2_AVG);
    end

    // Accumulator and sample counter; cleared whenever averaging is not active
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc_r        <= '0;
            sample_cnt_r <= '0;
        end else if ((state_r != ST_ACCUM) || !enable) begin
            acc_r        <= '0;
            sample_cnt_r <= '0;
        end else if (window_done_s) begin
            acc_r        <= '0;
            sample_cnt_r <= '0;
        end else if (take_s) begin
            acc_r        <= sum_s;
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
        end
    end

    // Result stage between the averager and the FIFO
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else begin
            res_valid_r <= window_done_s;
            if (window_done_s) begin
                res_data_r <= result_s;
            end
        end
    end

    // FIFO control: push/pop/drop decisions and next head value
    always_comb begin
        full_s       = (count_r == LW'(FIFO_DEPTH));
        pop_s        = avg_valid_r && avg_ready;
        wr_en_s      = res_valid_r && (!full_s || pop_s);
        drop_s       = res_valid_r && full_s && !pop_s;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = avg_data_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + LW'(1);
            2'b01:   count_nxt_s = count_r - LW'(1);
            default: count_nxt_s = count_r;
        endcase
        // The entry being written bypasses memory when it becomes the head.
        if (count_nxt_s == LW'(0)) begin
            head_nxt_s = avg_data_r;
        end else if (wr_en_s && ((count_r - LW'(pop_s)) == LW'(0))) begin
            head_nxt_s = res_data_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= res_data_r;
        end
    end

    // FIFO pointers, level and registered head outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            avg_valid_r <= 1'b0;
            avg_data_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            avg_valid_r <= (count_nxt_s != LW'(0));
            avg_data_r  <= head_nxt_s;
        end
    end

    // Sticky overflow and saturating drop counter; a drop outranks a clear
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clear_status) begin
                drop_cnt_r <= 16'd1;
            end else if (drop_cnt_r == 16'hFFFF) begin
                drop_cnt_r <= 16'hFFFF;
            end else begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end else if (clear_status) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end
    end

    assign avg_valid  = avg_valid_r;
    assign avg_data   = avg_data_r;
    assign fifo_level = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: window table plus reset, enable,
// backpressure, full-FIFO and pass-through sequences.
`timescale 1ns/1ps

module tb_adc_sample_averager;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable, new_data_flag, avg_ready, clear_status;
    logic [15:0] amplified_data;
    logic        avg_valid, overflow;
    logic [15:0] avg_data, drop_count;
    logic [3:0]  fifo_level;

    logic        en_pt, flag_pt, ready_pt, clr_pt;
    logic [15:0] data_pt;
    logic        valid_pt, ovf_pt;
    logic [15:0] avgd_pt, drop_pt;
    logic [3:0]  level_pt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] last;
        logic [15:0] exp;
    } win_vec_t;

    win_vec_t vecs [8];

    always #5 clk = ~clk;

    adc_sample_averager #(.ADC_WIDTH(16), .LOG2_AVG(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .areset(areset), .enable(enable), .new_data_flag(new_data_flag),
        .amplified_data(amplified_data), .avg_valid(avg_valid), .avg_data(avg_data),
        .avg_ready(avg_ready), .fifo_level(fifo_level), .overflow(overflow),
        .drop_count(drop_count), .clear_status(clear_status)
    );

    adc_sample_averager #(.ADC_WIDTH(16), .LOG2_AVG(0), .FIFO_DEPTH(8)) dut_pt (
        .clk(clk), .areset(areset), .enable(en_pt), .new_data_flag(flag_pt),
        .amplified_data(data_pt), .avg_valid(valid_pt), .avg_data(avgd_pt),
        .avg_ready(ready_pt), .fifo_level(level_pt), .overflow(ovf_pt),
        .drop_count(drop_pt), .clear_status(clr_pt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        new_data_flag  = 1'b1;
        amplified_data = v;
        step();
        new_data_flag  = 1'b0;
    endtask

    task automatic window(input logic [15:0] base, input logic [15:0] last);
        for (int i = 0; i < 15; i++) strobe(base);
        strobe(last);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!avg_valid && n < 20) begin
            step();
            n++;
        end
        check({name, "_valid"}, {31'd0, avg_valid}, 32'd1);
    endtask

    task automatic pop1();
        avg_ready = 1'b1;
        step();
        avg_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, {31'd0, avg_valid}, 32'd0);
        check({name, "_data"}, {16'd0, avg_data}, 32'd0);
        check({name, "_level"}, {28'd0, fifo_level}, 32'd0);
        check({name, "_ovf"}, {31'd0, overflow}, 32'd0);
        check({name, "_drops"}, {16'd0, drop_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd0,     16'd7,     16'd0};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  16'hFFFF};
        vecs[2] = '{16'd100,   16'd100,   16'd100};
        vecs[3] = '{16'd10,    16'd25,    16'd11};
        vecs[4] = '{16'd1,     16'd9,     16'd2};
        vecs[5] = '{16'd1,     16'd8,     16'd1};
        vecs[6] = '{16'hFFFF,  16'd0,     16'hEFFF};
        vecs[7] = '{16'd3,     16'd12,    16'd4};

        areset = 1'b1; enable = 1'b0; new_data_flag = 1'b0; amplified_data = 16'd0;
        avg_ready = 1'b0; clear_status = 1'b0;
        en_pt = 1'b0; flag_pt = 1'b0; data_pt = 16'd0; ready_pt = 1'b0; clr_pt = 1'b0;
        step(); step();
        check_idle_outputs("reset");
        areset = 1'b0;
        enable = 1'b1;
        step(); step();

        // Reset in the middle of a window discards the partial sum
        for (int i = 0; i < 5; i++) strobe(16'd50);
        #2 areset = 1'b1;
        #1 check_idle_outputs("midreset");
        #2 areset = 1'b0;
        step(); step();
        window(16'd100, 16'd100);
        wait_valid("t1");
        check("t1_data", {16'd0, avg_data}, 32'd100);
        pop1();
        step(); step(); step();
        check("t1_single", {31'd0, avg_valid}, 32'd0);
        check("t1_level", {28'd0, fifo_level}, 32'd0);

        // Latency: final strobe in T, result visible in T+2
        window(16'd0, 16'd8);
        check("lat_t1", {31'd0, avg_valid}, 32'd0);
        step();
        check("lat_t2", {31'd0, avg_valid}, 32'd1);
        check("lat_data", {16'd0, avg_data}, 32'd1);
        pop1();
        check("lat_popped", {31'd0, avg_valid}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            window(vecs[v].base, vecs[v].last);
            wait_valid($sformatf("vec%0d", v));
            check($sformatf("vec%0d_data", v), {16'd0, avg_data}, {16'd0, vecs[v].exp});
            check($sformatf("vec%0d_level", v), {28'd0, fifo_level}, 32'd1);
            pop1();
            check($sformatf("vec%0d_empty", v), {31'd0, avg_valid}, 32'd0);
        end

        // Enable dropped for one cycle abandons the partial window
        for (int i = 0; i < 10; i++) strobe(16'd50);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step(); step();
        window(16'd200, 16'd200);
        wait_valid("t3");
        check("t3_data", {16'd0, avg_data}, 32'd200);
        pop1();
        step(); step(); step();
        check("t3_single", {31'd0, avg_valid}, 32'd0);

        // Backpressure: ten results into an eight-entry FIFO
        for (int k = 1; k <= 10; k++) window(16'(k), 16'(k));
        step(); step(); step();
        check("bp_level", {28'd0, fifo_level}, 32'd8);
        check("bp_ovf", {31'd0, overflow}, 32'd1);
        check("bp_drops", {16'd0, drop_count}, 32'd2);
        check("bp_stable", {16'd0, avg_data}, 32'd1);
        avg_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("bp_valid%0d", i), {31'd0, avg_valid}, 32'd1);
            check($sformatf("bp_pop%0d", i), {16'd0, avg_data}, i);
            step();
        end
        avg_ready = 1'b0;
        check("bp_drained", {31'd0, avg_valid}, 32'd0);
        check("bp_hold", {16'd0, avg_data}, 32'd8);
        #2 areset = 1'b1;
        #1 check_idle_outputs("reset2");
        #2 areset = 1'b0;
        step(); step();

        // Full FIFO with push and pop on the same edge, then status clears
        for (int k = 21; k <= 28; k++) window(16'(k), 16'(k));
        step(); step();
        check("full_level", {28'd0, fifo_level}, 32'd8);
        window(16'd29, 16'd29);
        avg_ready = 1'b1;
        step();
        avg_ready = 1'b0;
        check("sim_level", {28'd0, fifo_level}, 32'd8);
        check("sim_drops", {16'd0, drop_count}, 32'd0);
        check("sim_ovf", {31'd0, overflow}, 32'd0);
        check("sim_head", {16'd0, avg_data}, 32'd22);
        window(16'd30, 16'd30);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clrdrop_ovf", {31'd0, overflow}, 32'd1);
        check("clrdrop_cnt", {16'd0, drop_count}, 32'd1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_cnt", {16'd0, drop_count}, 32'd0);
        avg_ready = 1'b1;
        for (int i = 22; i <= 29; i++) begin
            check($sformatf("full_pop%0d", i), {16'd0, avg_data}, i);
            step();
        end
        avg_ready = 1'b0;
        check("full_drained", {31'd0, avg_valid}, 32'd0);

        // Pass-through instance: one strobe per cycle straight to the output
        en_pt = 1'b1;
        ready_pt = 1'b1;
        step(); step();
        for (int c = 0; c <= 33; c++) begin
            flag_pt = (c < 32);
            data_pt = 16'(c);
            step();
            if (c == 0 || c == 33) begin
                check($sformatf("pt_idle%0d", c), {31'd0, valid_pt}, 32'd0);
            end else begin
                check($sformatf("pt_valid%0d", c - 1), {31'd0, valid_pt}, 32'd1);
                check($sformatf("pt_data%0d", c - 1), {16'd0, avgd_pt}, c - 1);
                check($sformatf("pt_level%0d", c - 1), {31'd0, level_pt <= 4'd1}, 32'd1);
            end
        end
        flag_pt = 1'b0;
        check("pt_drops", {16'd0, drop_pt}, 32'd0);
        check("pt_ovf", {31'd0, ovf_pt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
